// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer, LSB first; define SERIAL_ADDER_SUB_EN for the subtract option
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, b_in, nxt;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    count;
    logic             carry, c_in, fa_s, fa_c;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif
    assign fa_s = op_a[0] ^ op_b[0] ^ carry;
    assign fa_c = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    assign nxt  = {fa_s, res};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            count <= '0;
        end else if (state == RUN) begin
            carry <= fa_c;
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            res   <= nxt[WIDTH-1:1];
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
                sum   <= nxt;
                cout  <= fa_c;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
            end
        end else begin
            done  <= 1'b0;
            busy  <= start;
            state <= start ? RUN : IDLE;
            if (start) begin
                op_a  <= a;
                op_b  <= b_in;
                carry <= c_in;
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed checks of the bit-serial adder controller at WIDTH=8
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;
    int         tests = 0, failed = 0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic run_job(input string tag, input logic [7:0] ja, input logic [7:0] jb,
                           input logic jc, input logic [7:0] es, input logic ec);
        int nb = 0, n = 0;
        start = 1'b1; a = ja; b = jb; cin = jc;
        tick();
        start = 1'b0;
        while (!done && n < 30) begin
            if (busy) nb++;
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_cycles"}, 32'(nb), 8);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 0);
    endtask

    initial begin
        int n;
        int dn;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        #10 rst_n = 1'b1;
        tick();

        run_job("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_job("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_job("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("t3_done", 32'(done), 1);
        check("t3_sum", 32'(sum), 32'h02);
        check("t3_cout", 32'(cout), 0);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dn++;
        end
        check("t3_extra_done", 32'(dn), 0);
        check("t3_idle", 32'(busy), 0);

        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        tick();
        a = 8'h7F; b = 8'h01;
        wait_done(n);
        check("t4_done1", 32'(done), 1);
        check("t4_lat1", 32'(n), 8);
        check("t4_busy_low", 32'(busy), 0);
        check("t4_sum1", 32'(sum), 32'h30);
        tick();
        check("t4_rerun", 32'(busy), 1);
        check("t4_sum_hold", 32'(sum), 32'h30);
        wait_done(n);
        start = 1'b0;
        check("t4_done2", 32'(done), 1);
        check("t4_gap", 32'(n + 1), 9);
        check("t4_sum2", 32'(sum), 32'h80);
        check("t4_cout2", 32'(cout), 0);
        tick();

        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_sum", 32'(sum), 0);
        check("t5_cout", 32'(cout), 0);
        #12 rst_n = 1'b1;
        tick();
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) dn++;
            tick();
        end
        check("t5_no_resume", 32'(dn), 0);
        run_job("t5_new", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_job("t6a", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        run_job("t6b", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
        sub = 1'b0;
        run_job("t6c", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
